// File: rtl/regbank_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regbank_wr_arbiter
// Purpose  : Write-side controller for an 8 x WIDTH register bank. Shares the
//            bank's data bus and eight write enables between requesters A and
//            B (round-robin), rejects writes to locked registers, and runs an
//            8-cycle sequence that loads INIT_VALUE into every register.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_x/addr_x/data_x - requester x write request (x = a, b)
//            lock[7:0]           - lock[i]=1 rejects requester writes to reg i
//            init_start          - pulse: start the init sequence
//            d, en[7:0]          - bank data bus and one-hot write enables
//            gnt_x / err_x       - 1-cycle pulse: write issued / rejected
//            busy, init_done     - init running / last init write cycle
// Revision : 1.0 - initial release
// ============================================================================
module regbank_wr_arbiter #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [2:0]       addr_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [2:0]       addr_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic [7:0]       lock,
  input  logic             init_start,
  output logic [WIDTH-1:0] d,
  output logic [7:0]       en,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             err_a,
  output logic             err_b,
  output logic             busy,
  output logic             init_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_INIT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] init_cnt;
  logic       last_b;      // 1 when B won the most recent arbitration

  // A requester whose gnt/err pulse is showing right now has just been
  // served; its req is still the old transaction, so keep it out this cycle.
  logic             cand_a;
  logic             cand_b;
  logic             win_a;
  logic             win_b;
  logic [2:0]       win_addr;
  logic [WIDTH-1:0] win_data;
  logic             win_locked;

  assign cand_a     = req_a & ~(gnt_a | err_a);
  assign cand_b     = req_b & ~(gnt_b | err_b);
  // On a tie the requester that did not win last time goes first.
  assign win_a      = cand_a & (~cand_b | last_b);
  assign win_b      = cand_b & ~win_a;
  assign win_addr   = win_a ? addr_a : addr_b;
  assign win_data   = win_a ? data_a : data_b;
  assign win_locked = lock[win_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      init_cnt  <= 3'd0;
      last_b    <= 1'b1;
      d         <= '0;
      en        <= 8'd0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
      case (state)
        S_INIT: begin
          // Lock, requests and further init_start pulses are all ignored.
          d         <= INIT_VALUE;
          en        <= 8'd1 << init_cnt;
          busy      <= 1'b1;
          init_done <= (init_cnt == 3'd7);
          init_cnt  <= init_cnt + 3'd1;
          if (init_cnt == 3'd7) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          busy      <= 1'b0;
          init_done <= 1'b0;
          en        <= 8'd0;
          if (init_start) begin
            // Pending requests stay pending until init completes.
            state    <= S_INIT;
            init_cnt <= 3'd0;
          end else if (win_a | win_b) begin
            last_b <= win_b;
            if (win_locked) begin
              // Rejected: bus value is left as it was, no enable.
              err_a <= win_a;
              err_b <= win_b;
            end else begin
              d     <= win_data;
              en    <= 8'd1 << win_addr;
              gnt_a <= win_a;
              gnt_b <= win_b;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regbank_wr_arbiter
// Purpose  : Self-checking bench for regbank_wr_arbiter. A transaction-level
//            model predicts every output each cycle; a simple bank model is
//            driven from both the DUT and the prediction and compared too.
//            Directed scenarios add literal expectations, then a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wr_arbiter;

  localparam int          W  = 16;
  localparam logic [15:0] IV = 16'h00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, init_start = 1'b0;
  logic [2:0]    addr_a = 3'd0, addr_b = 3'd0;
  logic [W-1:0]  data_a = '0, data_b = '0;
  logic [7:0]    lock = 8'd0;
  logic [W-1:0]  d;
  logic [7:0]    en;
  logic          gnt_a, gnt_b, err_a, err_b, busy, init_done;

  regbank_wr_arbiter #(.WIDTH(W), .INIT_VALUE(IV)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .lock(lock), .init_start(init_start),
    .d(d), .en(en), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .err_a(err_a), .err_b(err_b), .busy(busy), .init_done(init_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] e_d = '0;
  logic [7:0]  e_en = '0;
  logic        e_ga = 0, e_gb = 0, e_ea = 0, e_eb = 0, e_busy = 0, e_done = 0;
  int          init_pos = -1;      // -1: idle, else next register to initialise
  bit          last_was_a = 0;
  bit          model_ok = 0;
  logic        bank_clr = 0;       // stands in for the bank's own reset
  logic [15:0] mbank [8];
  logic [15:0] dbank [8];
  logic        m_ca, m_cb;
  int          m_who;              // 0 none, 1 A, 2 B
  logic [2:0]  m_addr;
  logic [15:0] m_data;

  initial begin
    for (int i = 0; i < 8; i++) begin
      mbank[i] = '0;
      dbank[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bank_clr) mbank[i] = '0;
      else if (e_en[i]) mbank[i] = e_d;
    end
    m_ca = req_a && !(e_ga || e_ea);
    m_cb = req_b && !(e_gb || e_eb);
    {e_ga, e_gb, e_ea, e_eb, e_done} = '0;
    e_en = '0;
    if (reset) begin
      e_d = '0; e_busy = 0; init_pos = -1; last_was_a = 0; model_ok = 1;
    end else if (init_pos >= 0) begin
      e_d = IV;
      e_en = 8'h01 << init_pos;
      e_busy = 1;
      e_done = (init_pos == 7);
      init_pos = (init_pos == 7) ? -1 : init_pos + 1;
    end else begin
      e_busy = 0;
      if (init_start) begin
        init_pos = 0;
      end else begin
        if (m_ca && m_cb) m_who = last_was_a ? 2 : 1;
        else if (m_ca)    m_who = 1;
        else if (m_cb)    m_who = 2;
        else              m_who = 0;
        if (m_who != 0) begin
          m_addr = (m_who == 1) ? addr_a : addr_b;
          m_data = (m_who == 1) ? data_a : data_b;
          last_was_a = (m_who == 1);
          if (lock[m_addr]) begin
            e_ea = (m_who == 1);
            e_eb = (m_who == 2);
          end else begin
            e_d  = m_data;
            e_en = 8'h01 << m_addr;
            e_ga = (m_who == 1);
            e_gb = (m_who == 2);
          end
        end
      end
    end
  end

  // Bank as seen through the DUT's bus.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bank_clr) dbank[i] <= '0;
      else if (en[i] === 1'b1) dbank[i] <= d;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("d", d, e_d);
      chk("en", en, e_en);
      chk("gnt_a", gnt_a, e_ga);
      chk("gnt_b", gnt_b, e_gb);
      chk("err_a", err_a, e_ea);
      chk("err_b", err_b, e_eb);
      chk("busy", busy, e_busy);
      chk("init_done", init_done, e_done);
      chk("en_onehot", ($countones(en) <= 1), 1);
      for (int i = 0; i < 8; i++) chk("bank", dbank[i], mbank[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; bank_clr = 1; req_a = 0; req_b = 0; init_start = 0; lock = 0;
    cyc(2);
    reset = 0; bank_clr = 0;
  endtask

  task automatic init_walk(input string tag);
    logic [7:0] exp_en;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      exp_en = 8'h01 << k;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_en"}, en, exp_en);
      chk({tag, "_d"}, d, IV);
      chk({tag, "_done"}, init_done, (k == 7));
    end
  endtask

  initial begin
    logic [7:0] exp_en;
    cyc(1);
    do_reset();
    // reset state
    chk("rst_en", en, 0); chk("rst_busy", busy, 0); chk("rst_d", d, 0);

    // single write, then masked cycle with req still held
    req_a = 1; addr_a = 3'd3; data_a = 16'hBEEF;
    cyc(1);
    chk("s1_en", en, 8'h08); chk("s1_d", d, 16'hBEEF); chk("s1_gnt", gnt_a, 1);
    cyc(1);
    chk("s1_mask_gnt", gnt_a, 0); chk("s1_mask_en", en, 0); chk("s1_q3", dbank[3], 16'hBEEF);
    req_a = 0;
    cyc(1);
    chk("s1_idle_en", en, 0);

    // both held: alternate A/B every cycle, A first
    do_reset();
    req_a = 1; addr_a = 3'd1; data_a = 16'h1111;
    req_b = 1; addr_b = 3'd2; data_b = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      exp_en = (k % 2 == 0) ? 8'h02 : 8'h04;
      chk("s2_en", en, exp_en);
      chk("s2_gnt_a", gnt_a, (k % 2 == 0));
      chk("s2_gnt_b", gnt_b, (k % 2 == 1));
    end
    req_a = 0; req_b = 0;
    cyc(1);

    // locked B target, A to reg 0 unlocked
    do_reset();
    lock = 8'h20;
    req_a = 1; addr_a = 3'd0; data_a = 16'hAAAA;
    req_b = 1; addr_b = 3'd5; data_b = 16'h5555;
    cyc(1);
    chk("s3_gnt_a", gnt_a, 1); chk("s3_en", en, 8'h01); chk("s3_err_b0", err_b, 0);
    req_a = 0;
    cyc(1);
    chk("s3_err_b", err_b, 1); chk("s3_en_off", en, 0); chk("s3_gnt_b", gnt_b, 0);
    req_b = 0;
    cyc(1);
    chk("s3_err_pulse", err_b, 0); chk("s3_q5", dbank[5], 16'h0000); chk("s3_q0", dbank[0], 16'hAAAA);
    lock = 0;

    // init with a pending request
    do_reset();
    req_a = 1; addr_a = 3'd6; data_a = 16'h1234; init_start = 1;
    cyc(1);
    init_start = 0;
    chk("s4_no_gnt", gnt_a, 0); chk("s4_en0", en, 0);
    init_walk("s4");
    cyc(1);
    chk("s4_busy_low", busy, 0); chk("s4_gnt", gnt_a, 1); chk("s4_en_g", en, 8'h40); chk("s4_d_g", d, 16'h1234);
    for (int i = 0; i < 8; i++) chk("s4_q", dbank[i], IV);
    req_a = 0;
    cyc(1);

    // reset during 4th init cycle aborts, registers 0..3 already loaded
    do_reset();
    init_start = 1;
    cyc(1);
    init_start = 0;
    cyc(4);
    chk("s5_en4", en, 8'h08);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("s5_en_abort", en, 0); chk("s5_busy_abort", busy, 0);
    for (int i = 0; i < 8; i++) chk("s5_q", dbank[i], (i < 4) ? IV : 16'h0000);
    init_start = 1;
    cyc(1);
    init_start = 0;
    init_walk("s5r");
    cyc(1);
    for (int i = 0; i < 8; i++) chk("s5r_q", dbank[i], IV);

    // init_start and lock during init are ignored
    do_reset();
    init_start = 1;
    cyc(1);
    init_start = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      exp_en = 8'h01 << k;
      chk("s6_en", en, exp_en);
      chk("s6_done", init_done, (k == 7));
      if (k == 2) begin init_start = 1; lock = 8'hFF; end
      if (k == 3) init_start = 0;
    end
    lock = 0;
    cyc(1);
    chk("s6_busy_low", busy, 0); chk("s6_no_restart", en, 0);
    for (int i = 0; i < 8; i++) chk("s6_q", dbank[i], IV);

    // random traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if (!req_a || e_ga || e_ea) begin
        req_a = ($urandom % 3) != 0; addr_a = 3'($urandom); data_a = 16'($urandom);
      end
      if (!req_b || e_gb || e_eb) begin
        req_b = ($urandom % 3) != 0; addr_b = 3'($urandom); data_b = 16'($urandom);
      end
      if ($urandom % 16 == 0) lock = 8'($urandom);
      init_start = ($urandom % 60) == 0;
      reset = ($urandom % 300) == 0;
      cyc(1);
    end
    reset = 0; req_a = 0; req_b = 0; init_start = 0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
